// File: rtl/bcd_to_binary.sv
// Signed 3-digit BCD to 8-bit two's-complement converter (reverse double dabble).
// Define BCD_SATURATE_EN to saturate out-of-range results instead of zeroing them.
module bcd_to_binary #(
  parameter int CHECK_DIGITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       negative,
  output logic       busy,
  output logic       done,
  output logic [7:0] binary,
  output logic       error
);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] bcd_q, bcd_d;
  logic [9:0]  mag_q, mag_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        inv_q, inv_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  bin_q, bin_d;
  logic        err_q, err_d;

  logic [21:0] sh;
  logic [11:0] bcd_s;
  logic [9:0]  mag_s;
  logic        bad;
  logic        oor;

  assign bad = (CHECK_DIGITS != 0) &&
               ((hundreds > 4'd9) || (tens > 4'd9) ||
                (ones > 4'd9));

  assign oor = neg_q ? (mag_q > 10'd128) : (mag_q > 10'd127);

  // One reverse-dabble step: shift right, then correct each nibble.
  always_comb begin
    sh    = {bcd_q, mag_q} >> 1;
    bcd_s = sh[21:10];
    mag_s = sh[9:0];
    for (int i = 0; i < 3; i++) begin
      if (bcd_s[i*4 +: 4] >= 4'd8)
        bcd_s[i*4 +: 4] = bcd_s[i*4 +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    inv_d   = inv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = {hundreds, tens, ones};
          neg_d   = negative;
          mag_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          inv_d   = bad;
          state_d = bad ? FINISH : CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = bcd_s;
        mag_d = mag_s;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9)
          state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (inv_q) begin
          bin_d = 8'h00;
          err_d = 1'b1;
        end else if (oor) begin
`ifdef BCD_SATURATE_EN
          bin_d = neg_q ? 8'h80 : 8'h7F;
`else
          bin_d = 8'h00;
`endif
          err_d = 1'b1;
        end else begin
          bin_d = neg_q ? (~mag_q[7:0] + 8'd1)
                        : mag_q[7:0];
          err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      inv_q   <= inv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign binary = bin_q;
  assign error  = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary.
// Expected results are queued at start and popped on done.
module tb_bcd_to_binary;

  typedef struct {
    logic [7:0] bin;
    logic       err;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic [3:0] h = '0, t = '0, o = '0;
  logic       neg = 1'b0;
  logic       busy0, done0, err0;
  logic [7:0] bin0;
  logic       busy1, done1, err1;
  logic [7:0] bin1;

  int   checks = 0;
  int   failures = 0;
  int   ncyc = 0;
  exp_t sb[$];

`ifdef BCD_SATURATE_EN
  localparam logic [7:0] OOR_POS = 8'h7F;
`else
  localparam logic [7:0] OOR_POS = 8'h00;
`endif

  bcd_to_binary #(.CHECK_DIGITS(1)) u_dut (
    .clk(clk), .reset(reset), .start(start0),
    .hundreds(h), .tens(t), .ones(o),
    .negative(neg), .busy(busy0), .done(done0),
    .binary(bin0), .error(err0)
  );

  bcd_to_binary #(.CHECK_DIGITS(0)) u_nochk (
    .clk(clk), .reset(reset), .start(start1),
    .hundreds(h), .tens(t), .ones(o),
    .negative(neg), .busy(busy1), .done(done1),
    .binary(bin1), .error(err1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ncyc++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done0) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("binary", {24'd0, bin0}, {24'd0, e.bin});
        chk("error", {31'd0, err0}, {31'd0, e.err});
        chk("latency", ncyc, e.due);
        chk("busy_at_done", {31'd0, busy0}, 0);
      end
    end
  end

  task automatic drive(input logic [3:0] hh, tt, oo,
                       input logic nn,
                       input logic [7:0] eb,
                       input logic ee, input int lat);
    exp_t e;
    h = hh; t = tt; o = oo; neg = nn;
    start0 = 1'b1;
    e.bin = eb; e.err = ee; e.due = ncyc + lat + 1;
    sb.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic go(input logic [3:0] hh, tt, oo,
                    input logic nn,
                    input logic [7:0] eb,
                    input logic ee, input int lat);
    @(negedge clk);
    drive(hh, tt, oo, nn, eb, ee, lat);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout", 1, 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy0}, 0);
    chk("rst_done", {31'd0, done0}, 0);
    chk("rst_bin", {24'd0, bin0}, 0);
    chk("rst_err", {31'd0, err0}, 0);
    reset = 1'b0;

    // +127 with busy held for the whole conversion
    go(4'd1, 4'd2, 4'd7, 1'b0, 8'h7F, 1'b0, 11);
    chk("busy_run", {31'd0, busy0}, 1);
    repeat (10) begin
      @(negedge clk);
      chk("busy_run", {31'd0, busy0}, 1);
    end
    wait_empty();

    go(4'd1, 4'd2, 4'd8, 1'b1, 8'h80, 1'b0, 11);
    wait_empty();
    go(4'd0, 4'd0, 4'd0, 1'b1, 8'h00, 1'b0, 11);
    wait_empty();
    go(4'd0, 4'd4, 4'd2, 1'b1, 8'hD6, 1'b0, 11);
    wait_empty();
    go(4'd2, 4'd5, 4'd5, 1'b0, OOR_POS, 1'b1, 11);
    wait_empty();
    go(4'd0, 4'd0, 4'd0, 1'b0, 8'h00, 1'b0, 11);
    wait_empty();
    go(4'd0, 4'd0, 4'hA, 1'b0, 8'h00, 1'b1, 1);
    wait_empty();

    // unchecked instance converts 0,0,A arithmetically
    @(negedge clk);
    h = 4'd0; t = 4'd0; o = 4'hA; neg = 1'b0;
    start1 = 1'b1;
    c = ncyc;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("nochk_done", {31'd0, done1}, 1);
    chk("nochk_lat", ncyc - c, 12);
    chk("nochk_bin", {24'd0, bin1}, 32'h0A);
    chk("nochk_err", {31'd0, err1}, 0);
    repeat (2) @(negedge clk);

    // start while busy is ignored
    go(4'd0, 4'd9, 4'd9, 1'b0, 8'h63, 1'b0, 11);
    @(negedge clk);
    h = 4'd0; t = 4'd0; o = 4'd1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_empty();
    repeat (10) @(negedge clk);

    // start in the done cycle is accepted
    go(4'd0, 4'd5, 4'd0, 1'b0, 8'h32, 1'b0, 11);
    n = 0;
    while (!done0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, done0}, 1);
    drive(4'd1, 4'd0, 4'd0, 1'b0, 8'h64, 1'b0, 11);
    wait_empty();

    // reset mid-conversion: no done, outputs cleared
    @(negedge clk);
    h = 4'd0; t = 4'd5; o = 4'd5; neg = 1'b0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy0}, 0);
    chk("mid_rst_bin", {24'd0, bin0}, 0);
    chk("mid_rst_err", {31'd0, err0}, 0);
    chk("mid_rst_done", {31'd0, done0}, 0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    go(4'd0, 4'd3, 4'd3, 1'b1, 8'hDF, 1'b0, 11);
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Sequential converter from three signed-magnitude BCD digits (hundreds/tens/ones plus a sign flag) to an 8-bit two's-complement binary value.
- Inverse of the team's combinational binary-to-BCD display path; feeds keypad/BCD entry back into the 8-bit datapath.
- Uses reverse double dabble, one shift step per clock, with a start/busy/done handshake and range and digit checking.

Parameters:
- CHECK_DIGITS, 1, when 1 any digit > 9 aborts the conversion with error; when 0 digits are not checked and are converted arithmetically as given.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request conversion; sampled only in IDLE
- hundreds  input  4  BCD hundreds digit
- tens  input  4  BCD tens digit
- ones  input  4  BCD ones digit
- negative  input  1  1 = value is negative
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse; binary/error valid from this cycle
- binary  output  8  two's-complement result, held until the next done
- error  output  1  invalid digit or out of range, held with binary

Behaviour:
- Reset (synchronous, active-high, all registers): state IDLE; busy=0, done=0, binary=8'h00, error=0. Reset mid-conversion abandons the operation and no done pulse follows.
- States: IDLE, CONVERT, FINISH.
- IDLE, start=1 at edge N: capture digits and sign into a 12-bit BCD shift register and a sign register; clear the 10-bit magnitude register and the step counter; busy=1.
  - If CHECK_DIGITS=1 and any digit > 9: go to FINISH with the invalid flag set. Zero CONVERT steps.
  - Otherwise go to CONVERT.
- CONVERT: edges N+1 to N+10, one step per edge, 10 steps total.
  - Shift {bcd, mag} right by 1 as a single 22-bit concatenation.
  - Then, for each 4-bit BCD nibble, if the nibble is >= 8, subtract 3.
  - After step 10, go to FINISH.
- FINISH, one edge (N+11 normally, N+1 when invalid):
  - Invalid digit: binary=8'h00, error=1.
  - mag > 127 with negative=0, or mag > 128 with negative=1: out of range, see Optional Feature.
  - Otherwise: binary = negative ? (~mag[7:0] + 1) : mag[7:0]; error=0.
  - Set done=1 and busy=0, then return to IDLE.
- Latency: start at edge N gives done high in the cycle after edge N+11 (11 clocks); invalid digit gives done after edge N+1.
- done is high for exactly 1 cycle. binary and error keep their values until the next FINISH or reset.
- start while busy=1 is ignored; it is not queued.
- start in the same cycle that done is high is accepted, because the FSM is already in IDLE.
- Negative zero (negative=1, 000) gives 8'h00 with error=0.
- -128 (negative=1, 128) is legal and gives 8'h80.
- Inputs only need to be stable in the start cycle; later changes have no effect.

Optional Feature:
- Macro: BCD_SATURATE_EN.
- Defined: out-of-range results saturate to binary=8'h7F (positive) or 8'h80 (negative), with error=1.
- Not defined: out-of-range gives binary=8'h00, error=1.
- Invalid-digit handling is the same either way.

Test Plan:
- 1,2,7, negative=0, start pulse -> done exactly 11 clocks later; binary=8'h7F, error=0; busy high throughout.
- 1,2,8, negative=1 -> binary=8'h80, error=0. Then 0,0,0, negative=1 -> binary=8'h00, error=0.
- 0,4,2, negative=1 -> binary=8'hD6 (-42), error=0. Then 2,5,5, negative=0 -> error=1; binary=8'h00, or 8'h7F with BCD_SATURATE_EN.
- ones=4'hA, CHECK_DIGITS=1 -> done 1 clock after start; error=1, binary=8'h00. Repeat with CHECK_DIGITS=0 and 0,0,A -> binary=8'h0A, error=0.
- Start 0,9,9 and re-pulse start with 0,0,1 at clock 3 -> a single done with binary=8'h63. A start in the done cycle begins a new conversion immediately.
- Start a conversion and assert reset at clock 5 -> busy=0, binary=8'h00, error=0 the next cycle; no done pulse follows; the next start converts normally.
